// File: rtl/nios_core_mem_streamer.sv
// Streams a block of words from on-chip memory out as an Avalon-ST packet.
// A CSR bank sets start address and length; GO launches; DONE/ERR report status.
module nios_core_mem_streamer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    input  logic              csr_read,
    output logic [31:0]       csr_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop,
    output logic              irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [ADDR_W-1:0] r_start;
    logic [10:0]       r_length;
    logic              r_irq_en;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_readdata;

    logic [ADDR_W-1:0] r_addr;
    logic [10:0]       r_remaining;
    logic [10:0]       r_beat;
    logic              r_inflight;

    logic [31:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_go;
    logic              w_len_ok;
    logic              w_pop;
    logic              w_push;
    logic              w_last_beat;
    logic [CNT_W:0]    w_occ;
    logic              w_room;
    logic              w_issue;
    logic              w_busy;
    logic              w_go_ok;
    logic              w_go_err;
    logic              w_finish;
    logic [31:0]       w_rdata;
    logic              w_status_wr;

    assign w_go        = csr_write && (csr_address == 2'd2) && csr_writedata[0];
    assign w_status_wr = csr_write && (csr_address == 2'd3);
    assign w_len_ok    = (r_length != 11'd0) && (r_length <= 11'd1024);
    assign w_pop       = st_valid && st_ready;
    assign w_push      = r_inflight;
    assign w_last_beat = (r_beat == (r_length - 11'd1));

    // Reads already in flight will land next cycle, so they count against room.
    assign w_occ  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_room = (w_occ < (DEPTH_C + {{CNT_W{1'b0}}, w_pop}));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_busy       = 1'b0;
        w_go_ok      = 1'b0;
        w_go_err     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    if (w_len_ok) begin
                        w_go_ok      = 1'b1;
                        w_next_state = S_RUN;
                    end else begin
                        w_go_err = 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_room) begin
                    w_issue = 1'b1;
                    if (r_remaining == 11'd1) begin
                        w_next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (w_pop && w_last_beat) begin
                    w_finish     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_beat      <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_go_ok) begin
                r_addr      <= r_start;
                r_remaining <= r_length;
            end else if (w_issue) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 11'd1;
            end
            if (w_go_ok) begin
                r_beat <= '0;
            end else if (w_pop) begin
                r_beat <= r_beat + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= mem_readdata;
                r_wr_ptr         <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (csr_address)
            2'd0: w_rdata[ADDR_W-1:0] = r_start;
            2'd1: w_rdata[10:0]       = r_length;
            2'd2: w_rdata[1]          = r_irq_en;
            2'd3: w_rdata[2:0]        = {r_err, r_done, w_busy};
            default: w_rdata = '0;
        endcase
    end

    // Hardware set of DONE/ERR takes priority over a same-cycle W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start    <= '0;
            r_length   <= '0;
            r_irq_en   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (csr_write && !w_busy) begin
                if (csr_address == 2'd0) r_start  <= csr_writedata[ADDR_W-1:0];
                if (csr_address == 2'd1) r_length <= csr_writedata[10:0];
            end
            if (csr_write && (csr_address == 2'd2)) begin
                r_irq_en <= csr_writedata[1];
            end
            if (w_finish) begin
                r_done <= 1'b1;
            end else if (w_go_ok || (w_status_wr && csr_writedata[1])) begin
                r_done <= 1'b0;
            end
            if (w_go_err) begin
                r_err <= 1'b1;
            end else if (w_status_wr && csr_writedata[2]) begin
                r_err <= 1'b0;
            end
            if (csr_read) begin
                r_readdata <= w_rdata;
            end
        end
    end

    assign csr_readdata   = r_readdata;
    assign mem_address    = r_addr;
    assign mem_chipselect = w_issue;
    assign mem_write      = 1'b0;
    assign st_valid       = (r_count != '0);
    assign st_data        = r_fifo[r_rd_ptr];
    assign st_sop         = st_valid && (r_beat == 11'd0);
    assign st_eop         = st_valid && w_last_beat;
    assign irq            = r_done && r_irq_en;

endmodule
